// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue slice.
package inst_fetch_queue_pkg;

  typedef logic [31:0] Word_t;
  typedef logic [31:0] InstAddr_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } ExceptInfo_t;

  typedef struct packed {
    Word_t       inst;
    InstAddr_t   pc;
    ExceptInfo_t except;
  } FetchEntry_t;

  localparam int unsigned FETCH_WIDTH_DEFAULT = 2;
  localparam int unsigned ISSUE_WIDTH_DEFAULT = 2;
  localparam int unsigned DEPTH_DEFAULT       = 8;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// IF->ID handshake bundle for the fetch queue; slave = queue, master = pipeline.
interface inst_fetch_queue_if
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = FETCH_WIDTH_DEFAULT,
  parameter int unsigned ISSUE_WIDTH = ISSUE_WIDTH_DEFAULT,
  parameter int unsigned DEPTH       = DEPTH_DEFAULT
) ();
  localparam int unsigned PCW = $clog2(FETCH_WIDTH + 1);
  localparam int unsigned TKW = $clog2(ISSUE_WIDTH + 1);
  localparam int unsigned OCW = $clog2(DEPTH + 1);

  logic                                flush;
  logic                                push_valid;
  logic                                push_ready;
  logic [PCW-1:0]                      push_count;
  Word_t       [FETCH_WIDTH-1:0]       push_inst;
  InstAddr_t                           push_pc;
  ExceptInfo_t                         push_except;
  logic [ISSUE_WIDTH-1:0]              issue_valid;
  Word_t       [ISSUE_WIDTH-1:0]       issue_inst;
  InstAddr_t   [ISSUE_WIDTH-1:0]       issue_pc;
  ExceptInfo_t [ISSUE_WIDTH-1:0]       issue_except;
  logic [TKW-1:0]                      issue_taken;
  logic [OCW-1:0]                      occupancy;

  modport slave (
    input  flush, push_valid, push_count, push_inst, push_pc, push_except, issue_taken,
    output push_ready, issue_valid, issue_inst, issue_pc, issue_except, occupancy
  );

  modport master (
    output flush, push_valid, push_count, push_inst, push_pc, push_except, issue_taken,
    input  push_ready, issue_valid, issue_inst, issue_pc, issue_except, occupancy
  );
endinterface

// File: rtl/inst_fetch_queue_ram.sv
// DEPTH-entry register array: FETCH_WIDTH indexed write ports, ISSUE_WIDTH async reads.
module fetch_queue_ram
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH       = DEPTH_DEFAULT,
  parameter int unsigned FETCH_WIDTH = FETCH_WIDTH_DEFAULT,
  parameter int unsigned ISSUE_WIDTH = ISSUE_WIDTH_DEFAULT,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic        [FETCH_WIDTH-1:0]          i_we,
  input  logic        [FETCH_WIDTH-1:0][AW-1:0]  i_widx,
  input  FetchEntry_t [FETCH_WIDTH-1:0]          i_wdata,
  input  logic        [ISSUE_WIDTH-1:0][AW-1:0]  i_ridx,
  output FetchEntry_t [ISSUE_WIDTH-1:0]          o_rdata
);
  FetchEntry_t [DEPTH-1:0] r_mem;

  // Storage update: each enabled lane writes its own entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem <= '0;
    end else begin
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
        if (i_we[i]) r_mem[i_widx[i]] <= i_wdata[i];
      end
    end
  end

  // Asynchronous read ports feeding the issue slots.
  always_comb begin
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      o_rdata[k] = r_mem[i_ridx[k]];
    end
  end
endmodule

// File: rtl/inst_fetch_queue.sv
// Circular IF->ID instruction queue with wrap-bit pointers.
// Optional zero-latency empty-queue bypass: INST_FETCH_QUEUE_BYPASS_EN.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = FETCH_WIDTH_DEFAULT,
  parameter int unsigned ISSUE_WIDTH = ISSUE_WIDTH_DEFAULT,
  parameter int unsigned DEPTH       = DEPTH_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_queue_if.slave fq
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned OCW = $clog2(DEPTH + 1);

  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [PW-1:0] w_occ;
  int unsigned   w_occ_u, w_push_cnt, w_taken, w_q_vis, w_pop, w_skip, w_wr_adv;
  logic          w_push_ready, w_push_fire, w_byp;

  logic        [FETCH_WIDTH-1:0]          w_we;
  logic        [FETCH_WIDTH-1:0][AW-1:0]  w_widx;
  FetchEntry_t [FETCH_WIDTH-1:0]          w_wdata;
  logic        [ISSUE_WIDTH-1:0][AW-1:0]  w_ridx;
  FetchEntry_t [ISSUE_WIDTH-1:0]          w_rdata;

  assign w_occ          = r_wr_ptr - r_rd_ptr;
  assign fq.occupancy   = OCW'(w_occ);
  assign fq.push_ready  = w_push_ready;

  // Pointer arithmetic: acceptance from registered occupancy, clamped pop, bypass skip.
  always_comb begin
    w_occ_u      = 32'(w_occ);
    w_push_ready = (DEPTH - w_occ_u) >= FETCH_WIDTH;
    w_push_cnt   = min_u(32'(fq.push_count), FETCH_WIDTH);
    w_push_fire  = fq.push_valid & w_push_ready & ~fq.flush & (w_push_cnt != 0);
    w_taken      = 32'(fq.issue_taken);
    w_q_vis      = min_u(w_occ_u, ISSUE_WIDTH);
    w_pop        = min_u(w_taken, w_q_vis);
`ifdef INST_FETCH_QUEUE_BYPASS_EN
    w_byp        = w_push_fire && (w_occ_u == 0);
    w_skip       = w_byp ? min_u(w_taken, min_u(w_push_cnt, ISSUE_WIDTH)) : 0;
`else
    w_byp        = 1'b0;
    w_skip       = 0;
`endif
    w_wr_adv     = w_push_fire ? (w_push_cnt - w_skip) : 0;
  end

  // Write lanes: bypass-consumed lanes are skipped, the rest pack down from wr_ptr.
  always_comb begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      w_we[i]    = w_push_fire && (i >= w_skip) && (i < w_push_cnt);
      w_widx[i]  = AW'(r_wr_ptr + PW'(i - w_skip));
      w_wdata[i] = '{inst: fq.push_inst[i], pc: fq.push_pc + (4 * i), except: fq.push_except};
    end
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      w_ridx[k] = AW'(r_rd_ptr + PW'(k));
    end
  end

  // Issue slots: bypassed push lanes when empty, otherwise queue entries; idle slots read 0.
  always_comb begin
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      fq.issue_valid[k]  = 1'b0;
      fq.issue_inst[k]   = '0;
      fq.issue_pc[k]     = '0;
      fq.issue_except[k] = '0;
      if (w_byp && (k < w_push_cnt)) begin
        fq.issue_valid[k]  = 1'b1;
        fq.issue_inst[k]   = fq.push_inst[k];
        fq.issue_pc[k]     = fq.push_pc + (4 * k);
        fq.issue_except[k] = fq.push_except;
      end else if (k < w_q_vis) begin
        fq.issue_valid[k]  = 1'b1;
        fq.issue_inst[k]   = w_rdata[k].inst;
        fq.issue_pc[k]     = w_rdata[k].pc;
        fq.issue_except[k] = w_rdata[k].except;
      end
`ifdef INST_FETCH_QUEUE_BYPASS_EN
      if (fq.flush) begin
        fq.issue_valid[k]  = 1'b0;
        fq.issue_inst[k]   = '0;
        fq.issue_pc[k]     = '0;
        fq.issue_except[k] = '0;
      end
`endif
    end
  end

  // Pointer registers: flush beats push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (fq.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_wr_ptr <= r_wr_ptr + PW'(w_wr_adv);
    end
  end

  fetch_queue_ram #(
    .DEPTH      (DEPTH),
    .FETCH_WIDTH(FETCH_WIDTH),
    .ISSUE_WIDTH(ISSUE_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we),
    .i_widx (w_widx),
    .i_wdata(w_wdata),
    .i_ridx (w_ridx),
    .o_rdata(w_rdata)
  );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue (FETCH_WIDTH=2, ISSUE_WIDTH=2, DEPTH=8).
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int unsigned FW    = 2;
  localparam int unsigned IW    = 2;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH)) fq ();

  inst_fetch_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .fq (fq)
  );

  FetchEntry_t exp_q[$];
  int unsigned pend   = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare the presented slots with the oldest expected entries, then retire.
  always @(negedge clk) begin
    int unsigned held, vis, n;
    logic [IW-1:0] m;
    if (mon_en) begin
      held = exp_q.size() - pend;
      vis  = (held < IW) ? held : IW;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
      if (held == 0) vis = (exp_q.size() < IW) ? exp_q.size() : IW;
      if (fq.flush) vis = 0;
`endif
      chk("occupancy", 64'(fq.occupancy), 64'(held));
      chk("push_ready", 64'(fq.push_ready), 64'((DEPTH - held) >= FW));
      m = '0;
      for (int unsigned k = 0; k < vis; k++) m[k] = 1'b1;
      chk("issue_valid", 64'(fq.issue_valid), 64'(m));
      for (int unsigned k = 0; k < vis; k++) begin
        chk($sformatf("slot%0d_inst", k), 64'(fq.issue_inst[k]), 64'(exp_q[k].inst));
        chk($sformatf("slot%0d_pc", k), 64'(fq.issue_pc[k]), 64'(exp_q[k].pc));
        chk($sformatf("slot%0d_except", k), 64'(fq.issue_except[k]), 64'(exp_q[k].except));
      end
      if (fq.flush) begin
        exp_q.delete();
      end else begin
        n = 32'(fq.issue_taken);
        if (n > vis) n = vis;
        repeat (n) void'(exp_q.pop_front());
      end
      pend = 0;
    end
  end

  // One stimulus cycle; acc marks a group the queue is expected to accept.
  task automatic cyc(input bit pv, input int unsigned cnt, input logic [31:0] i0,
                     input logic [31:0] i1, input logic [31:0] pc,
                     input int unsigned taken, input bit fl, input bit acc);
    ExceptInfo_t e;
    @(posedge clk);
    #1;
    e = '{valid: pc[3], code: pc[7:4]};
    fq.push_valid   = pv;
    fq.push_count   = 2'(cnt);
    fq.push_inst[0] = i0;
    fq.push_inst[1] = i1;
    fq.push_pc      = pc;
    fq.push_except  = e;
    fq.issue_taken  = 2'(taken);
    fq.flush        = fl;
    if (acc) begin
      for (int unsigned i = 0; i < cnt; i++)
        exp_q.push_back('{inst: (i == 0) ? i0 : i1, pc: pc + (4 * i), except: e});
      pend = cnt;
    end
  endtask

  initial begin
    rst            = 1'b0;
    fq.flush       = 1'b0;
    fq.push_valid  = 1'b0;
    fq.push_count  = '0;
    fq.push_inst   = '0;
    fq.push_pc     = '0;
    fq.push_except = '0;
    fq.issue_taken = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_occupancy", 64'(fq.occupancy), 64'd0);
    chk("rst_issue_valid", 64'(fq.issue_valid), 64'd0);
    chk("rst_push_ready", 64'(fq.push_ready), 64'd1);
    chk("rst_issue_inst", 64'(fq.issue_inst), 64'd0);
    chk("rst_issue_pc", 64'(fq.issue_pc), 64'd0);
    chk("rst_issue_except", 64'(fq.issue_except), 64'd0);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;

    // Basic push, then fill to full and check push_ready gating.
    cyc(1, 2, 32'h11, 32'h22, 32'h8000_0000, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 2, 32'h33, 32'h44, 32'h8000_0008, 0, 0, 1);
    cyc(1, 2, 32'h55, 32'h66, 32'h8000_0010, 0, 0, 1);
    cyc(1, 2, 32'h77, 32'h88, 32'h8000_0018, 0, 0, 1);
    cyc(1, 2, 32'h99, 32'hAA, 32'h8000_0020, 0, 0, 0);
    // Pop 2, then a group that wraps into entries 0..1.
    cyc(0, 0, 0, 0, 0, 2, 0, 0);
    cyc(1, 2, 32'h99, 32'hAA, 32'h8000_0020, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 2, 0, 0);
    cyc(0, 0, 0, 0, 0, 2, 0, 0);
    cyc(0, 0, 0, 0, 0, 2, 0, 0);
    // Occupancy 3 with single pops, then clamped and over-large issue_taken.
    cyc(1, 1, 32'hBB, 32'h0, 32'h8000_0100, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 2, 0, 0);
    cyc(0, 0, 0, 0, 0, 3, 0, 0);
    // push_count = 0 must not push.
    cyc(1, 0, 32'hDEAD, 32'hBEEF, 32'h0000_0500, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Build occupancy 5, then flush together with a push and a pop.
    cyc(1, 2, 32'hC1, 32'hC2, 32'h0000_0200, 0, 0, 1);
    cyc(1, 2, 32'hC3, 32'hC4, 32'h0000_0208, 0, 0, 1);
    cyc(1, 1, 32'hC5, 32'h0, 32'h0000_0210, 0, 0, 1);
    cyc(1, 2, 32'hE1, 32'hE2, 32'h0000_0300, 2, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Empty-queue push with a same-cycle take, then simultaneous push and pop.
    cyc(1, 2, 32'hA, 32'hB, 32'h0000_0408, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'hC, 32'h0, 32'h0000_0410, 2, 0, 1);
    cyc(0, 0, 0, 0, 0, 2, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised decoupling buffer between the IF stage and the ID stage of the superscalar pipeline. It replaces the single "leftover instruction" register with a circular queue. The queue accepts fetch groups of up to FETCH_WIDTH instructions per cycle and presents the oldest ISSUE_WIDTH instructions to the decoders in program order. It retires however many instructions the issue logic takes each cycle, and it empties on a pipeline flush.

## Interface
- FETCH_WIDTH, 2: maximum instructions written per cycle (≥1).
- ISSUE_WIDTH, 2: instruction slots presented to ID (≥1).
- DEPTH, 8: queue entries. Power of two, ≥ max(FETCH_WIDTH, ISSUE_WIDTH).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset. Reset is asserted while rst=0.
- flush  in  1  synchronous flush from ctrl, exception or redirect.
- push_valid  in  1  a fetch group is presented.
- push_ready  out  1  queue has ≥FETCH_WIDTH free entries.
- push_count  in  $clog2(FETCH_WIDTH+1)  valid instructions in the group, range 1..FETCH_WIDTH.
- push_inst  in  FETCH_WIDTH×32  group instructions; lane 0 is the oldest.
- push_pc  in  32  PC of lane 0.
- push_except  in  ExceptInfo_t  fetch exception; applies to every lane of the group.
- issue_valid  out  ISSUE_WIDTH  slot valid mask, always contiguous from slot 0.
- issue_inst  out  ISSUE_WIDTH×32  oldest instructions; slot 0 is the oldest.
- issue_pc  out  ISSUE_WIDTH×32  per-slot PC.
- issue_except  out  ISSUE_WIDTH×ExceptInfo_t  per-slot exception.
- issue_taken  in  $clog2(ISSUE_WIDTH+1)  instructions consumed by ID this cycle.
- occupancy  out  $clog2(DEPTH+1)  current entry count, for debug and performance counters.

## Operation
- Storage: DEPTH entries of {inst, pc, except}.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - occupancy = wr_ptr − rd_ptr, modulo 2^(log2 DEPTH + 1).
  - Empty when the pointers are equal; full when only the MSB differs.
- Push fires when push_valid & push_ready & ~flush.
  - Lane i, for i < push_count, is written to entry (wr_ptr+i) mod DEPTH with pc = push_pc + 4·i.
  - wr_ptr advances by push_count.
- push_ready = (DEPTH − occupancy) ≥ FETCH_WIDTH.
  - It is computed from registered occupancy only. There is no combinational path from issue_taken to push_ready.
- Issue slot k is valid when k < occupancy. Its contents come from entry (rd_ptr+k) mod DEPTH.
- Pop: rd_ptr advances by min(issue_taken, popcount(issue_valid)).
  - The queue clamps an over-large issue_taken; it never underflows.
- Simultaneous push and pop in one cycle: both apply, and the new occupancy = old + pushed − popped.
- Flush has priority over everything else. At the next edge rd_ptr = wr_ptr = 0, and the same-cycle push and pop are both discarded.
- Push with push_count = 0 is illegal. The design treats it as no push.

## Timing
- Reset values: rd_ptr = wr_ptr = 0, occupancy = 0, issue_valid = 0, push_ready = 1. issue_inst, issue_pc and issue_except are 0.
- Push-to-issue latency is 1 cycle. A group accepted at edge N is visible at the issue outputs after edge N.
- Pop takes effect at the same edge. Slots shift so that the next-oldest entry appears in slot 0 after that edge.
- Wrap-around is invisible at the ports. Groups straddling entry DEPTH−1 → 0 issue in order.
- Reset asserted mid-operation clears all state immediately (asynchronous). Any in-flight push is lost.

## Configuration
- INST_FETCH_QUEUE_BYPASS_EN defined:
  - When the queue is empty and a push fires, issue slots 0..push_count−1 are driven combinationally from push lanes. Zero-cycle latency.
  - issue_taken may consume bypassed instructions. Only the untaken remainder is written, and wr_ptr advances by push_count − taken.
  - Flush still suppresses the bypass: issue_valid = 0 in a flush cycle.
- INST_FETCH_QUEUE_BYPASS_EN undefined:
  - Strict 1-cycle latency.
  - No combinational path from push to issue.

## Structure
- The shared cpu_defs package gains:
  - FetchEntry_t {Word_t inst; InstAddr_t pc; ExceptInfo_t except}.
  - The constants FETCH_WIDTH_DEFAULT and ISSUE_WIDTH_DEFAULT.
- One sub-module, fetch_queue_ram: a DEPTH×FetchEntry_t register array.
  - FETCH_WIDTH write ports with per-port enable and index.
  - ISSUE_WIDTH asynchronous read ports.
- Pointer arithmetic, clamping and the bypass mux stay in inst_fetch_queue.

## Test plan
- Reset with rst=0 for 3 cycles, then release → issue_valid=0, push_ready=1, occupancy=0.
- Push {0x11,0x22} with pc=0x80000000, issue_taken=0 → next cycle issue_valid=2'b11, issue_pc={0x80000000,0x80000004}, occupancy=2.
- DEPTH=8 with 4 pushes of 2 and no pops → occupancy=8, push_ready=0. One pop of 2 → push_ready=1 the next cycle; a subsequent push wraps to entries 0..1 and issues in order.
- occupancy=3 with issue_taken=1 → slot 0 holds the former slot 1 next cycle, occupancy=2. issue_taken=2 with occupancy=1 → clamps to 1 pop, occupancy=0.
- Flush asserted together with a push (push_count=2) and issue_taken=2 at occupancy 5 → next cycle occupancy=0, issue_valid=0, and nothing from the pushed group appears.
- With INST_FETCH_QUEUE_BYPASS_EN, empty queue, push {0xA,0xB} with issue_taken=1 → same cycle slot 0 = 0xA. Next cycle slot 0 = 0xB, occupancy=1.
